// File: rtl/fetch_arb_pkg.sv
// fetch_arb_pkg: shared FSM encoding, way indices and default widths for the fetch arbiter.
package fetch_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DRAIN} state_t;
  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/inst_fetch_arbiter_if.sv
// inst_fetch_arbiter_if: fetch-unit and I-memory signals of the arbiter; master is the arbiter side.
interface inst_fetch_arbiter_if
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              jumpFlag_i;
  logic              w0_request_i;
  logic [ADDR_W-1:0] w0_instAddr_i;
  logic              w0_dataOk_o;
  logic [DATA_W-1:0] w0_inst_o;
  logic              w1_request_i;
  logic [ADDR_W-1:0] w1_instAddr_i;
  logic              w1_dataOk_o;
  logic [DATA_W-1:0] w1_inst_o;
  logic              mem_request_o;
  logic [ADDR_W-1:0] mem_instAddr_o;
  logic              mem_dataOk_i;
  logic [DATA_W-1:0] mem_inst_i;
  logic              err_o;
  modport master (
    input  jumpFlag_i, w0_request_i, w0_instAddr_i, w1_request_i, w1_instAddr_i,
    input  mem_dataOk_i, mem_inst_i,
    output w0_dataOk_o, w0_inst_o, w1_dataOk_o, w1_inst_o,
    output mem_request_o, mem_instAddr_o, err_o
  );
  modport slave (
    output jumpFlag_i, w0_request_i, w0_instAddr_i, w1_request_i, w1_instAddr_i,
    output mem_dataOk_i, mem_inst_i,
    input  w0_dataOk_o, w0_inst_o, w1_dataOk_o, w1_inst_o,
    input  mem_request_o, mem_instAddr_o, err_o
  );
endinterface

// File: rtl/fetch_arb_rr_pick2.sv
// fetch_arb_rr_pick2: two-way round-robin picker; a lone requester wins, a tie goes to the way not granted last.
module fetch_arb_rr_pick2
  import fetch_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = (&i_req) ? ((i_last == WAY0) ? 2'b10 : 2'b01) : i_req;
  end
endmodule

// File: rtl/inst_fetch_arbiter.sv
// inst_fetch_arbiter: shares one I-memory port between two fetch ways, one transaction in flight.
// Optional watchdog on BUSY/DRAIN enabled by defining FETCH_ARB_TIMEOUT_EN.
module inst_fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef FETCH_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
)(
  input  logic                 clk,
  input  logic                 reset,
  inst_fetch_arbiter_if.master bus
);
  state_t            r_state, w_next;
  logic              r_last, r_w0_ok, r_w1_ok;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_w0_inst, r_w1_inst;
  logic [1:0]        w_elig, w_grant;
  logic              w_take, w_busy, w_deliver, w_to;
  // A way whose data pulse is out this cycle is masked so it is not granted twice.
  assign w_elig = {bus.w1_request_i & ~r_w1_ok, bus.w0_request_i & ~r_w0_ok};
  fetch_arb_rr_pick2 u_pick (.i_req(w_elig), .i_last(r_last), .o_grant(w_grant));
  assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_take    = (r_state == IDLE) && !bus.jumpFlag_i && |w_grant;
  assign w_deliver = w_busy && bus.mem_dataOk_i && !bus.jumpFlag_i;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_take ? (w_grant[0] ? BUSY0 : BUSY1) : IDLE;
    else if (bus.mem_dataOk_i || w_to) w_next = IDLE;
    else if (bus.jumpFlag_i) w_next = DRAIN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last    <= WAY1;
      r_addr    <= '0;
      r_w0_ok   <= 1'b0;
      r_w1_ok   <= 1'b0;
      r_w0_inst <= '0;
      r_w1_inst <= '0;
    end else begin
      r_w0_ok <= w_deliver && (r_state == BUSY0);
      r_w1_ok <= w_deliver && (r_state == BUSY1);
      if (w_deliver && (r_state == BUSY0)) r_w0_inst <= bus.mem_inst_i;
      if (w_deliver && (r_state == BUSY1)) r_w1_inst <= bus.mem_inst_i;
      if (w_take) begin
        r_last <= w_grant[1] ? WAY1 : WAY0;
        r_addr <= w_grant[0] ? bus.w0_instAddr_i : bus.w1_instAddr_i;
      end
    end
  end
`ifdef FETCH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign w_to = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Counter restarts whenever BUSYx or DRAIN is freshly entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state != IDLE && w_next == r_state) ? r_cnt + 1'b1 : '0;
      r_err <= w_to && !bus.mem_dataOk_i;
    end
  end
  assign bus.err_o = r_err;
`else
  assign w_to      = 1'b0;
  assign bus.err_o = 1'b0;
`endif
  assign bus.mem_request_o  = (r_state != IDLE);
  assign bus.mem_instAddr_o = r_addr;
  assign bus.w0_dataOk_o    = r_w0_ok;
  assign bus.w0_inst_o      = r_w0_inst;
  assign bus.w1_dataOk_o    = r_w1_ok;
  assign bus.w1_inst_o      = r_w1_inst;
endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// tb_inst_fetch_arbiter: directed vector table plus hand-written multi-cycle sequences for inst_fetch_arbiter.
module tb_inst_fetch_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  inst_fetch_arbiter_if bus ();
`ifdef FETCH_ARB_TIMEOUT_EN
  inst_fetch_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));
`else
  inst_fetch_arbiter dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif
  // c = {reset, jump, w0_req, w1_req, mem_dataOk}; e = {mem_req, w0_ok, w1_ok}
  typedef struct {
    logic [4:0]  c;
    logic [31:0] a0, a1, mi;
    logic [2:0]  e;
    logic [31:0] ea, ei0, ei1;
  } vec_t;
  vec_t vt [35];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    int   n_req, n_ok;
    logic prev;
    vt = '{
      '{5'b00000, 'h000, 'h000, 'h00,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00100, 'h100, 'h000, 'h00,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00100, 'h100, 'h000, 'h00,   3'b100, 'h100, 'h00, 'h00},
      '{5'b00100, 'h100, 'h000, 'h00,   3'b100, 'h100, 'h00, 'h00},
      '{5'b00101, 'h100, 'h000, 'h13,   3'b100, 'h100, 'h00, 'h00},
      '{5'b00100, 'h100, 'h000, 'h00,   3'b010, 'h100, 'h13, 'h00},
      '{5'b00000, 'h100, 'h000, 'h00,   3'b000, 'h100, 'h13, 'h00},
      '{5'b10000, 'h000, 'h000, 'h00,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00110, 'h200, 'h300, 'h00,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00111, 'h200, 'h300, 'hA0,   3'b100, 'h200, 'h00, 'h00},
      '{5'b00110, 'h200, 'h300, 'h00,   3'b010, 'h200, 'hA0, 'h00},
      '{5'b00111, 'h200, 'h300, 'hB1,   3'b100, 'h300, 'hA0, 'h00},
      '{5'b00110, 'h200, 'h300, 'h00,   3'b001, 'h300, 'hA0, 'hB1},
      '{5'b00111, 'h200, 'h300, 'hA2,   3'b100, 'h200, 'hA0, 'hB1},
      '{5'b00110, 'h200, 'h300, 'h00,   3'b010, 'h200, 'hA2, 'hB1},
      '{5'b00011, 'h200, 'h300, 'hB3,   3'b100, 'h300, 'hA2, 'hB1},
      '{5'b00010, 'h200, 'h300, 'h00,   3'b001, 'h300, 'hA2, 'hB3},
      '{5'b00000, 'h200, 'h300, 'h00,   3'b000, 'h300, 'hA2, 'hB3},
      '{5'b00100, 'h400, 'h300, 'h00,   3'b000, 'h300, 'hA2, 'hB3},
      '{5'b00100, 'h400, 'h300, 'h00,   3'b100, 'h400, 'hA2, 'hB3},
      '{5'b01100, 'h400, 'h300, 'h00,   3'b100, 'h400, 'hA2, 'hB3},
      '{5'b00000, 'h400, 'h300, 'h00,   3'b100, 'h400, 'hA2, 'hB3},
      '{5'b01000, 'h400, 'h300, 'h00,   3'b100, 'h400, 'hA2, 'hB3},
      '{5'b00000, 'h400, 'h300, 'h00,   3'b100, 'h400, 'hA2, 'hB3},
      '{5'b00001, 'h400, 'h300, 'hDEAD, 3'b100, 'h400, 'hA2, 'hB3},
      '{5'b00000, 'h400, 'h300, 'h00,   3'b000, 'h400, 'hA2, 'hB3},
      '{5'b00010, 'h400, 'h500, 'h00,   3'b000, 'h400, 'hA2, 'hB3},
      '{5'b00010, 'h400, 'h500, 'h00,   3'b100, 'h500, 'hA2, 'hB3},
      '{5'b01111, 'h600, 'h500, 'hBAD,  3'b100, 'h500, 'hA2, 'hB3},
      '{5'b01110, 'h600, 'h504, 'h00,   3'b000, 'h500, 'hA2, 'hB3},
      '{5'b00110, 'h600, 'h504, 'h00,   3'b000, 'h500, 'hA2, 'hB3},
      '{5'b00110, 'h600, 'h504, 'h00,   3'b100, 'h600, 'hA2, 'hB3},
      '{5'b10110, 'h600, 'h504, 'h00,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00001, 'h600, 'h504, 'h77,   3'b000, 'h000, 'h00, 'h00},
      '{5'b00000, 'h000, 'h000, 'h00,   3'b000, 'h000, 'h00, 'h00}
    };
    bus.jumpFlag_i = 1'b0;
    bus.w0_request_i = 1'b0;
    bus.w0_instAddr_i = '0;
    bus.w1_request_i = 1'b0;
    bus.w1_instAddr_i = '0;
    bus.mem_dataOk_i = 1'b0;
    bus.mem_inst_i = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      {reset, bus.jumpFlag_i, bus.w0_request_i, bus.w1_request_i, bus.mem_dataOk_i} = vt[i].c;
      bus.w0_instAddr_i = vt[i].a0;
      bus.w1_instAddr_i = vt[i].a1;
      bus.mem_inst_i = vt[i].mi;
      #3;
      chk($sformatf("vec%0d", i),
          {28'b0, bus.mem_request_o, bus.mem_instAddr_o, bus.w0_dataOk_o, bus.w0_inst_o,
           bus.w1_dataOk_o, bus.w1_inst_o, bus.err_o},
          {28'b0, vt[i].e[2], vt[i].ea, vt[i].e[1], vt[i].ei0, vt[i].e[0], vt[i].ei1, 1'b0});
    end
    // Request held through its own pulse must cost exactly one memory transaction.
    n_req = 0;
    n_ok = 0;
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      bus.mem_dataOk_i = 1'b0;
      bus.w1_request_i = (n_ok == 0);
      bus.w1_instAddr_i = 32'h700;
      #3;
      if (bus.mem_request_o && !prev) n_req++;
      if (bus.mem_request_o) begin
        bus.mem_dataOk_i = 1'b1;
        bus.mem_inst_i = 32'h55;
      end
      if (bus.w1_dataOk_o) n_ok++;
      if (bus.w0_dataOk_o) n_ok += 100;
      prev = bus.mem_request_o;
    end
    chk("hold_mem_txns", 128'(n_req), 128'(1));
    chk("hold_pulses", 128'(n_ok), 128'(1));
    chk("hold_w1_inst", 128'(bus.w1_inst_o), 128'(32'h55));
`ifdef FETCH_ARB_TIMEOUT_EN
    begin
      int   n_busy;
      logic seen;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.mem_dataOk_i = 1'b0;
      bus.w1_request_i = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.w0_request_i = 1'b1;
      bus.w0_instAddr_i = 32'h800;
      n_busy = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk);
        #4;
        if (bus.err_o) seen = 1'b1;
        else if (bus.mem_request_o) n_busy++;
      end
      chk("to_err_seen", 128'(seen), 128'(1));
      chk("to_busy_cycles", 128'(n_busy), 128'(8));
      chk("to_idle", {bus.mem_request_o, bus.w0_dataOk_o}, 128'(0));
      @(posedge clk);
      #4;
      chk("to_regrant", {bus.mem_request_o, bus.err_o, bus.mem_instAddr_o}, {2'b10, 32'h800});
      reset = 1'b1;
      #1;
      chk("to_reset_busy", {bus.mem_request_o, bus.mem_instAddr_o, bus.w0_dataOk_o, bus.err_o}, 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.w0_request_i = 1'b0;
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
